// File: rtl/lcd_resultado_escrita.sv
// lcd_resultado_escrita: takes a signed calculator result (sign + 16-bit magnitude),
// converts the magnitude to BCD, and writes a signed decimal string to an HD44780 LCD.
// It runs the LCD power-up initialisation itself after reset.
// Ports:
//   clk, rst_n         - clock; synchronous active-low reset
//   saida, sinal_saida - result magnitude and sign (1 = negative)
//   valido             - input valid; accepted when pronto=1
//   pronto             - idle and ready to accept a value
//   EN, RS, RW, data   - 8-bit parallel LCD bus (RW is always 0, write only)
module lcd_resultado_escrita #(
  parameter int unsigned POWER_WAIT = 750000,
  parameter int unsigned EN_PULSE   = 25,
  parameter int unsigned WAIT_CMD   = 2500,
  parameter int unsigned WAIT_CLEAR = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] saida,
  input  logic        sinal_saida,
  input  logic        valido,
  output logic        pronto,
  output logic        EN,
  output logic        RS,
  output logic        RW,
  output logic [7:0]  data
);

  localparam int unsigned CONV_STEPS = 16;
  localparam int unsigned MAX_A   = (POWER_WAIT > EN_PULSE) ? POWER_WAIT : EN_PULSE;
  localparam int unsigned MAX_B   = (WAIT_CMD > WAIT_CLEAR) ? WAIT_CMD : WAIT_CLEAR;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CNT = (MAX_C > CONV_STEPS) ? MAX_C : CONV_STEPS;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_POWER,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_IDLE,
    S_CONV
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         idx, idx_nxt;
  logic               in_init, in_init_nxt;
  logic [15:0]        mag, mag_nxt;
  logic               neg, neg_nxt;
  logic [15:0]        shf, shf_nxt;
  logic [19:0]        bcd, bcd_nxt;
  logic               pronto_nxt, en_nxt, rs_nxt;
  logic [7:0]         data_nxt;
  logic               load;
  logic [19:0]        adj;
  logic [CNT_W-1:0]   hold_last;

  // Write only: RW never leaves 0.
  assign RW = 1'b0;

  // {RS, data} for byte i of the init sequence or of the result string.
  function automatic logic [8:0] byte_of(input logic init, input logic [2:0] i,
                                         input logic ng, input logic [15:0] m,
                                         input logic [19:0] b);
    int unsigned pos;
    logic [19:0] upper;
    byte_of = 9'h000;
    pos     = 0;
    if (init) begin
      case (i)
        3'd0:    byte_of = 9'h038;
        3'd1:    byte_of = 9'h00C;
        3'd2:    byte_of = 9'h001;
        default: byte_of = 9'h006;
      endcase
    end else begin
      case (i)
        3'd0:    byte_of = 9'h080;
        3'd1:    byte_of = {1'b1, (ng && (m != 16'd0)) ? 8'h2D : 8'h20};
        3'd2:    pos = 4;
        3'd3:    pos = 3;
        3'd4:    pos = 2;
        3'd5:    pos = 1;
        default: pos = 0;
      endcase
      if (i >= 3'd2) begin
        // upper holds this digit and every more significant one; all zero means leading zero
        upper = b >> (4 * pos);
        if ((upper == 20'd0) && (pos != 0))
          byte_of = 9'h120;
        else
          byte_of = {1'b1, 4'h3, upper[3:0]};
      end
    end
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < 5; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // The clear command needs the long settle time.
  assign hold_last = ((data == 8'h01) && !RS) ? CNT_W'(WAIT_CLEAR - 1) : CNT_W'(WAIT_CMD - 1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    in_init_nxt = in_init;
    mag_nxt     = mag;
    neg_nxt     = neg;
    shf_nxt     = shf;
    bcd_nxt     = bcd;
    pronto_nxt  = pronto;
    en_nxt      = EN;
    rs_nxt      = RS;
    data_nxt    = data;
    load        = 1'b0;

    case (state)
      S_POWER: begin
        if (cnt == CNT_W'(POWER_WAIT - 1)) begin
          state_nxt   = S_SETUP;
          cnt_nxt     = '0;
          idx_nxt     = 3'd0;
          in_init_nxt = 1'b1;
          load        = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_SETUP: begin
        state_nxt = S_PULSE;
        en_nxt    = 1'b1;
        cnt_nxt   = '0;
      end
      S_PULSE: begin
        if (cnt == CNT_W'(EN_PULSE - 1)) begin
          state_nxt = S_HOLD;
          en_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == hold_last) begin
          cnt_nxt = '0;
          if (idx == (in_init ? 3'd3 : 3'd6)) begin
            state_nxt  = S_IDLE;
            pronto_nxt = 1'b1;
          end else begin
            state_nxt = S_SETUP;
            idx_nxt   = idx + 3'd1;
            load      = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (valido) begin
          state_nxt  = S_CONV;
          pronto_nxt = 1'b0;
          mag_nxt    = saida;
          neg_nxt    = sinal_saida;
          shf_nxt    = saida;
          bcd_nxt    = '0;
          cnt_nxt    = '0;
        end
      end
      S_CONV: begin
        bcd_nxt = {adj[18:0], shf[15]};
        shf_nxt = {shf[14:0], 1'b0};
        if (cnt == CNT_W'(CONV_STEPS - 1)) begin
          state_nxt   = S_SETUP;
          cnt_nxt     = '0;
          idx_nxt     = 3'd0;
          in_init_nxt = 1'b0;
          load        = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_POWER;
        cnt_nxt   = '0;
      end
    endcase

    // RS/data change only when a byte enters SETUP and then stay put through HOLD.
    if (load)
      {rs_nxt, data_nxt} = byte_of(in_init_nxt, idx_nxt, neg, mag, bcd);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_POWER;
      cnt     <= '0;
      idx     <= '0;
      in_init <= 1'b1;
      mag     <= '0;
      neg     <= 1'b0;
      shf     <= '0;
      bcd     <= '0;
      pronto  <= 1'b0;
      EN      <= 1'b0;
      RS      <= 1'b0;
      data    <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      in_init <= in_init_nxt;
      mag     <= mag_nxt;
      neg     <= neg_nxt;
      shf     <= shf_nxt;
      bcd     <= bcd_nxt;
      pronto  <= pronto_nxt;
      EN      <= en_nxt;
      RS      <= rs_nxt;
      data    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_resultado_escrita.sv
// Testbench for lcd_resultado_escrita: a cycle-level expected-waveform model
// (queue of per-cycle frames built from byte timing rules and decimal arithmetic)
// is compared against the DUT every cycle, plus literal byte/latency checks.
module tb_lcd_resultado_escrita;

  localparam int P_PW   = 10;
  localparam int P_EN   = 2;
  localparam int P_WCMD = 4;
  localparam int P_WCL  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] saida = 16'd0;
  logic        sinal_saida = 1'b0;
  logic        valido = 1'b0;
  logic        pronto, EN, RS, RW;
  logic [7:0]  data;

  lcd_resultado_escrita #(
    .POWER_WAIT(P_PW), .EN_PULSE(P_EN), .WAIT_CMD(P_WCMD), .WAIT_CLEAR(P_WCL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .saida(saida), .sinal_saida(sinal_saida),
    .valido(valido), .pronto(pronto), .EN(EN), .RS(RS), .RW(RW), .data(data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
  endtask

  // ---------------- expected-waveform model ----------------
  typedef struct packed {
    logic       pronto;
    logic       en;
    logic       rs;
    logic [7:0] data;
  } frame_t;

  frame_t q[$];
  frame_t cur;
  bit     model_on = 1'b0;

  function automatic void push_byte(input bit rs, input bit [7:0] d);
    frame_t f;
    int hold;
    hold = (!rs && d == 8'h01) ? P_WCL : P_WCMD;
    f = {1'b0, 1'b0, rs, d};
    q.push_back(f);
    f.en = 1'b1;
    for (int i = 0; i < P_EN; i++) q.push_back(f);
    f.en = 1'b0;
    for (int i = 0; i < hold; i++) q.push_back(f);
  endfunction

  function automatic void push_write(input int v, input bit ng);
    int pw;
    int dd;
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, (ng && v != 0) ? 8'h2D : 8'h20);
    pw = 10000;
    for (int p = 4; p >= 0; p--) begin
      dd = (v / pw) % 10;
      if (p > 0 && v < pw) push_byte(1'b1, 8'h20);
      else push_byte(1'b1, 8'(48 + dd));
      pw = pw / 10;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      cur = '0;
      for (int i = 1; i < P_PW; i++) q.push_back(frame_t'(0));
      push_byte(1'b0, 8'h38);
      push_byte(1'b0, 8'h0C);
      push_byte(1'b0, 8'h01);
      push_byte(1'b0, 8'h06);
      model_on = 1'b1;
    end else if (cur.pronto && valido) begin
      cur.pronto = 1'b0;
      cur.en     = 1'b0;
      for (int i = 1; i < 16; i++) q.push_back(cur);
      push_write(int'(saida), sinal_saida);
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur.pronto = 1'b1;
      cur.en     = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on)
      chk("cycle", {20'd0, pronto, EN, RS, RW, data},
          {20'd0, cur.pronto, cur.en, cur.rs, 1'b0, cur.data});
  end

  // ---------------- byte log from EN rising edges ----------------
  logic [8:0] blog[$];
  int         rises[$];
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    if (EN === 1'b1 && en_prev !== 1'b1) begin
      blog.push_back({RS, data});
      rises.push_back(cyc);
    end
    en_prev = EN;
  end

  task automatic wait_pronto(output int k);
    k = 0;
    while (k < 500) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (pronto === 1'b1) break;
    end
  endtask

  task automatic check_init(input string nm);
    int k;
    wait_pronto(k);
    chk({nm, "_pronto_latency"}, k, 42);
    chk({nm, "_nbytes"}, blog.size(), 4);
    if (blog.size() >= 4) begin
      chk({nm, "_b0"}, blog[0], 9'h038);
      chk({nm, "_b1"}, blog[1], 9'h00C);
      chk({nm, "_b2"}, blog[2], 9'h001);
      chk({nm, "_b3"}, blog[3], 9'h006);
      chk({nm, "_gap01"}, rises[1] - rises[0], 7);
      chk({nm, "_gap12"}, rises[2] - rises[1], 7);
      chk({nm, "_gap23"}, rises[3] - rises[2], 11);
    end
  endtask

  task automatic check_write(input string nm, input logic [47:0] e);
    chk({nm, "_nbytes"}, blog.size(), 7);
    if (blog.size() >= 1) chk({nm, "_addr"}, blog[0], 9'h080);
    for (int i = 1; i < 7; i++)
      if (i < blog.size()) chk({nm, "_char"}, blog[i], {1'b1, e[(6-i)*8 +: 8]});
  endtask

  // Called at a negedge with pronto=1; returns busy latency from the accept edge.
  task automatic send(input int v, input bit s, output int k);
    blog.delete();
    saida = 16'(v);
    sinal_saida = s;
    valido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    saida = 16'($urandom);
    sinal_saida = 1'($urandom);
    wait_pronto(k);
  endtask

  initial begin
    int k;
    int t;
    int v;
    bit s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {23'd0, pronto, EN, RS, RW, data}, 32'd0);
    rst_n = 1'b1;
    blog.delete();
    rises.delete();

    // Power-up init
    check_init("init");

    // Known values
    send(255, 1'b0, k);
    chk("busy_255", k, 65);
    check_write("w255", {8'h20, 8'h20, 8'h20, 8'h32, 8'h35, 8'h35});
    send(65025, 1'b1, k);
    chk("busy_65025", k, 65);
    check_write("w65025n", {8'h2D, 8'h36, 8'h35, 8'h30, 8'h32, 8'h35});
    send(0, 1'b1, k);
    check_write("wneg0", {8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30});
    send(1000, 1'b0, k);
    check_write("w1000", {8'h20, 8'h20, 8'h31, 8'h30, 8'h30, 8'h30});

    // valido held while busy: ignored until the first idle cycle
    blog.delete();
    saida = 16'd12;
    sinal_saida = 1'b0;
    valido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    saida = 16'd99;
    chk("busy_after_accept", pronto, 1'b0);
    wait_pronto(k);
    chk("busy_12", k, 65);
    check_write("w12", {8'h20, 8'h20, 8'h20, 8'h20, 8'h31, 8'h32});
    blog.delete();
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    chk("accept_99", pronto, 1'b0);
    wait_pronto(k);
    chk("busy_99", k, 65);
    check_write("w99", {8'h20, 8'h20, 8'h20, 8'h20, 8'h39, 8'h39});

    // Randomized values, checked cycle by cycle against the model
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = 65535;
        2: v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 65535));
      endcase
      s = 1'($urandom);
      send(v, s, k);
      chk("rand_busy", k, 65);
    end

    // Reset in the middle of a write while EN=1
    blog.delete();
    saida = 16'd4321;
    sinal_saida = 1'b1;
    valido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valido = 1'b0;
    t = 0;
    while (!(EN === 1'b1 && blog.size() >= 3) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("midwrite_en_high", EN, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_en", EN, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_pronto", pronto, 1'b0);
    rst_n = 1'b1;
    blog.delete();
    rises.delete();
    check_init("reinit");
    send(7, 1'b1, k);
    check_write("w7n", {8'h2D, 8'h20, 8'h20, 8'h20, 8'h20, 8'h37});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
